// File: rtl/fifo_wr_arbiter_if.sv
// Shared write-port bundle between the requesters, the FIFO write side and the round-robin arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned NREQ  = 4
) ();
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IW-1:0]         grant_id;
    logic                  busy;

    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, winc, wdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters in bursts of up to BURST beats.
module fifo_wr_arbiter #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4
) (
    input  logic               wclk,
    input  logic               wrst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] pick;
    logic [CW-1:0] beat_cnt;
    logic          own;
    logic          last_beat;

    // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NREQ
    always_comb begin
        int unsigned idx;
        idx  = 0;
        pick = rr_ptr;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = 32'(rr_ptr) + 32'(k);
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[IW'(idx)]) pick = IW'(idx);
        end
    end

    always_comb begin
        owner_nxt = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
        last_beat = bus.req_last[owner] || (beat_cnt == CW'(BURST - 1));
    end

    // Write-port outputs follow the owner directly so a beat moves in the cycle it is offered
    always_comb begin
        own           = (state == OWN) && !wrst;
        bus.winc      = own && bus.req_valid[owner] && !bus.wfull;
        bus.req_ready = '0;
        if (bus.winc) bus.req_ready[owner] = 1'b1;
        bus.wdata     = own ? bus.req_data[32'(owner) * DSIZE +: DSIZE] : '0;
        bus.grant_id  = wrst ? '0 : owner;
        bus.busy      = own;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    // wfull with valid data holds the grant and the count unchanged
                    if (bus.winc) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= owner_nxt;
                        end
                    end else if (!bus.req_valid[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= owner_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus scripted multi-cycle sequences.
module tb_fifo_wr_arbiter;
    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.DSIZE(8), .NREQ(4)) bus ();

    fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .BURST(4)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic       exp_winc;
        logic [3:0] exp_ready;
        logic [7:0] exp_wdata;
        logic [1:0] exp_gid;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[$];

    int n_vec = 0;
    int n_err = 0;

    int         nxt [4];
    int         lim [4];
    logic [7:0] base[4];
    logic       full_r;
    logic       rst_r;
    logic [7:0] q_data[$];
    int         q_gid [$];
    logic [31:0] trace, btrace, rtrace;
    int         cyc_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic w, input logic [3:0] rd, input logic [7:0] wd,
                       input logic [1:0] g, input logic b);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.full = f;
        t.exp_winc = w; t.exp_ready = rd; t.exp_wdata = wd; t.exp_gid = g; t.exp_busy = b;
        tbl.push_back(t);
    endtask

    // One clock of requester-model stimulus; logs every accepted beat
    task automatic cyc();
        wrst      = rst_r;
        bus.wfull = full_r;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]       = (nxt[i] < lim[i]);
            bus.req_data[i*8 +: 8] = base[i] + 8'(nxt[i]);
            bus.req_last[i]        = 1'b0;
        end
        @(negedge wclk);
        if (cyc_n < 32) begin
            trace[cyc_n]  = bus.winc;
            btrace[cyc_n] = bus.busy;
            rtrace[cyc_n] = |bus.req_ready;
        end
        if (bus.winc) begin
            chk("wdata_known", 32'($isunknown(bus.wdata)), 32'd0);
            q_data.push_back(bus.wdata);
            q_gid.push_back(int'(bus.grant_id));
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.req_ready[i]) begin
                chk("ready_gid", 32'(bus.grant_id), 32'(i));
                chk("ready_data", 32'(bus.wdata), 32'(base[i] + 8'(nxt[i])));
                nxt[i]++;
            end
        end
        @(posedge wclk);
        #1;
        cyc_n++;
    endtask

    task automatic clear_log();
        q_data.delete();
        q_gid.delete();
        trace = '0; btrace = '0; rtrace = '0;
        cyc_n = 0;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            nxt[i] = 0; lim[i] = 0; base[i] = 8'h00;
        end
        full_r = 1'b0;
        rst_r  = 1'b0;
    endtask

    task automatic do_reset();
        rst_r = 1'b1;
        cyc();
        rst_r = 1'b0;
    endtask

    initial begin
        logic [7:0] exp6[8];
        int         gid6[8];
        int         g;

        wrst          = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.wfull     = 1'b0;

        // rst valid last full | winc ready wdata gid busy ; requester i data = 0x10*(i+1)
        add(1, 4'hF, 4'h0, 0,  0, 4'h0, 8'h00, 2'd0, 0);
        add(1, 4'hF, 4'h0, 0,  0, 4'h0, 8'h00, 2'd0, 0);
        add(1, 4'hF, 4'h0, 0,  0, 4'h0, 8'h00, 2'd0, 0);
        add(0, 4'hF, 4'h0, 0,  0, 4'h0, 8'h00, 2'd0, 0);
        add(0, 4'hF, 4'h0, 0,  1, 4'h1, 8'h10, 2'd0, 1);
        add(0, 4'h8, 4'h0, 0,  0, 4'h0, 8'h10, 2'd0, 1);
        add(0, 4'h8, 4'h0, 0,  0, 4'h0, 8'h00, 2'd0, 0);
        add(0, 4'h8, 4'h8, 0,  1, 4'h8, 8'h40, 2'd3, 1);
        add(0, 4'hF, 4'h0, 0,  0, 4'h0, 8'h00, 2'd3, 0);
        add(0, 4'hF, 4'h0, 0,  1, 4'h1, 8'h10, 2'd0, 1);
        add(0, 4'hF, 4'h1, 1,  0, 4'h0, 8'h10, 2'd0, 1);
        add(0, 4'hF, 4'h1, 0,  1, 4'h1, 8'h10, 2'd0, 1);
        add(0, 4'hF, 4'h0, 0,  0, 4'h0, 8'h00, 2'd0, 0);
        add(0, 4'hF, 4'h0, 0,  1, 4'h2, 8'h20, 2'd1, 1);

        @(posedge wclk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            wrst          = tbl[i].rst;
            bus.req_valid = tbl[i].valid;
            bus.req_last  = tbl[i].last;
            bus.wfull     = tbl[i].full;
            bus.req_data  = 32'h4030_2010;
            @(negedge wclk);
            chk($sformatf("v%0d_winc", i),  32'(bus.winc),      32'(tbl[i].exp_winc));
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("v%0d_wdata", i), 32'(bus.wdata),     32'(tbl[i].exp_wdata));
            chk($sformatf("v%0d_gid", i),   32'(bus.grant_id),  32'(tbl[i].exp_gid));
            chk($sformatf("v%0d_busy", i),  32'(bus.busy),      32'(tbl[i].exp_busy));
            @(posedge wclk);
            #1;
        end

        // Single requester streaming ten beats: bursts 4,4,2 with one bubble between
        clear_src();
        do_reset();
        clear_log();
        lim[1] = 10; base[1] = 8'hA0;
        for (int c = 0; c < 14; c++) cyc();
        chk("t2_count", 32'(q_data.size()), 32'd10);
        for (int k = 0; k < q_data.size() && k < 10; k++) begin
            chk("t2_data", 32'(q_data[k]), 32'(8'hA0 + 8'(k)));
            chk("t2_gid", 32'(q_gid[k]), 32'd1);
        end
        chk("t2_winc_trace", trace, 32'h0000_1BDE);

        // All requesters continuously valid: grants 0,1,2,3,0 with four beats each
        clear_src();
        do_reset();
        clear_log();
        for (int i = 0; i < 4; i++) begin
            lim[i] = 20; base[i] = 8'(i * 8'h40);
        end
        for (int c = 0; c < 25; c++) cyc();
        chk("t3_count", 32'(q_data.size()), 32'd20);
        for (int k = 0; k < q_data.size() && k < 20; k++) begin
            g = (k / 4) % 4;
            chk("t3_gid", 32'(q_gid[k]), 32'(g));
            chk("t3_data", 32'(q_data[k]), 32'(base[g] + 8'(4 * (k / 16) + k % 4)));
        end
        chk("t3_winc_trace", trace, 32'h01EF_7BDE);

        // wfull held five cycles before the third beat of requester 2
        clear_src();
        do_reset();
        clear_log();
        lim[2] = 4; base[2] = 8'h30;
        for (int c = 0; c < 11; c++) begin
            full_r = (c >= 3 && c <= 7);
            cyc();
        end
        chk("t4_count", 32'(q_data.size()), 32'd4);
        for (int k = 0; k < q_data.size() && k < 4; k++) begin
            chk("t4_data", 32'(q_data[k]), 32'(8'h30 + 8'(k)));
            chk("t4_gid", 32'(q_gid[k]), 32'd2);
        end
        chk("t4_winc_trace", trace, 32'h0000_0306);
        chk("t4_ready_trace", rtrace, 32'h0000_0306);
        chk("t4_busy_trace", btrace, 32'h0000_03FE);

        // Reset on the third beat of requester 1 while rr_ptr sits at 3
        exp6 = '{8'h50, 8'h51, 8'h60, 8'h61, 8'h52, 8'h53, 8'h54, 8'h55};
        gid6 = '{1, 1, 0, 0, 1, 1, 1, 1};
        clear_src();
        clear_log();
        lim[1] = 10; base[1] = 8'h50;
        for (int c = 0; c < 14; c++) begin
            rst_r = (c == 3);
            if (c == 4) begin
                lim[0] = 2; base[0] = 8'h60;
                lim[3] = 4; base[3] = 8'h70;
            end
            cyc();
        end
        rst_r = 1'b0;
        chk("t6_count", 32'(q_data.size()), 32'd8);
        for (int k = 0; k < q_data.size() && k < 8; k++) begin
            chk("t6_data", 32'(q_data[k]), 32'(exp6[k]));
            chk("t6_gid", 32'(q_gid[k]), 32'(gid6[k]));
        end
        chk("t6_winc_trace", trace, 32'h0000_1E66);
        chk("t6_busy_trace", btrace, 32'h0000_1EE6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
